// File: rtl/pipe_occupancy_tracker.sv
// Shadow model of a CPU pipeline: tracks instruction word and valid bit per stage
// under stall (bubble insertion) and flush (front-stage kill), plus saturating event counters.
module pipe_occupancy_tracker #(
    parameter int STAGES      = 5,
    parameter int IW          = 32,
    parameter int CNTW        = 16,
    parameter int STALL_POINT = 1,
    parameter int FLUSH_DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [IW-1:0]          if_instr,
    input  logic                   if_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   clr,
    output logic [STAGES*IW-1:0]   stage_instr,
    output logic [STAGES-1:0]      stage_valid,
    output logic                   retire_valid,
    output logic [IW-1:0]          retire_instr,
    output logic [4:0]             occupancy,
    output logic [CNTW-1:0]        cycle_cnt,
    output logic [CNTW-1:0]        retired_cnt,
    output logic [CNTW-1:0]        stall_cnt,
    output logic [CNTW-1:0]        flush_cnt
);

    if (STAGES < 2 || STAGES > 16) begin : g_bad_stages
        $error("pipe_occupancy_tracker: STAGES must be 2..16");
    end
    if (STALL_POINT < 1 || STALL_POINT > STAGES - 1) begin : g_bad_stall_point
        $error("pipe_occupancy_tracker: STALL_POINT must be 1..STAGES-1");
    end
    if (FLUSH_DEPTH < 1 || FLUSH_DEPTH > STAGES - 1) begin : g_bad_flush_depth
        $error("pipe_occupancy_tracker: FLUSH_DEPTH must be 1..STAGES-1");
    end

    logic [STAGES-1:0]         valid_q, valid_d;
    logic [STAGES-1:0][IW-1:0] instr_q, instr_d;
    logic [CNTW-1:0]           cycle_q, cycle_d;
    logic [CNTW-1:0]           retired_q, retired_d;
    logic [CNTW-1:0]           stall_q, stall_d;
    logic [CNTW-1:0]           flush_q, flush_d;
    logic [4:0]                occ;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (v == {CNTW{1'b1}}) ? v : v + CNTW'(1);
    endfunction

    // Stage 0 is always inside the flush window and always below the stall point.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        if (flush) begin
            valid_d[0] = 1'b0;
            instr_d[0] = '0;
        end else if (!stall) begin
            valid_d[0] = if_valid;
            instr_d[0] = if_valid ? if_instr : '0;
        end
        for (int i = 1; i < STAGES; i++) begin
            if ((flush && i < FLUSH_DEPTH) || (!flush && stall && i == STALL_POINT)) begin
                valid_d[i] = 1'b0;
                instr_d[i] = '0;
            end else if (!flush && stall && i < STALL_POINT) begin
                valid_d[i] = valid_q[i];
                instr_d[i] = instr_q[i];
            end else begin
                valid_d[i] = valid_q[i-1];
                instr_d[i] = instr_q[i-1];
            end
        end
    end

    // clr wins over any event in the same cycle.
    always_comb begin
        cycle_d   = '0;
        retired_d = '0;
        stall_d   = '0;
        flush_d   = '0;
        if (!clr) begin
            cycle_d   = sat_inc(cycle_q);
            retired_d = valid_q[STAGES-1] ? sat_inc(retired_q) : retired_q;
            stall_d   = (stall && !flush) ? sat_inc(stall_q) : stall_q;
            flush_d   = flush ? sat_inc(flush_q) : flush_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q   <= '0;
            instr_q   <= '0;
            cycle_q   <= '0;
            retired_q <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            instr_q   <= instr_d;
            cycle_q   <= cycle_d;
            retired_q <= retired_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + 5'(valid_q[i]);
        end
    end

    assign stage_instr  = instr_q;
    assign stage_valid  = valid_q;
    assign retire_valid = valid_q[STAGES-1];
    assign retire_instr = instr_q[STAGES-1];
    assign occupancy    = occ;
    assign cycle_cnt    = cycle_q;
    assign retired_cnt  = retired_q;
    assign stall_cnt    = stall_q;
    assign flush_cnt    = flush_q;

endmodule

// File: tb/tb_pipe_occupancy_tracker.sv
// Directed bench for pipe_occupancy_tracker (5 stages, stall point 1, flush depth 2,
// 4-bit counters so saturation is reachable in a short run).
module tb_pipe_occupancy_tracker;

    localparam int STAGES = 5;
    localparam int IW     = 32;
    localparam int CNTW   = 4;

    logic                 clock;
    logic                 reset;
    logic [IW-1:0]        if_instr;
    logic                 if_valid;
    logic                 stall;
    logic                 flush;
    logic                 clr;
    logic [STAGES*IW-1:0] stage_instr;
    logic [STAGES-1:0]    stage_valid;
    logic                 retire_valid;
    logic [IW-1:0]        retire_instr;
    logic [4:0]           occupancy;
    logic [CNTW-1:0]      cycle_cnt;
    logic [CNTW-1:0]      retired_cnt;
    logic [CNTW-1:0]      stall_cnt;
    logic [CNTW-1:0]      flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_occupancy_tracker #(
        .STAGES(STAGES), .IW(IW), .CNTW(CNTW), .STALL_POINT(1), .FLUSH_DEPTH(2)
    ) dut (
        .clock(clock), .reset(reset), .if_instr(if_instr), .if_valid(if_valid),
        .stall(stall), .flush(flush), .clr(clr),
        .stage_instr(stage_instr), .stage_valid(stage_valid),
        .retire_valid(retire_valid), .retire_instr(retire_instr),
        .occupancy(occupancy), .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [STAGES*IW-1:0] obs,
                       input logic [STAGES*IW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [IW-1:0] ins, input logic st,
                         input logic fl, input logic cl);
        if_valid = v;
        if_instr = ins;
        stall    = st;
        flush    = fl;
        clr      = cl;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    logic [IW-1:0] a, b, c, d, e, f, x, y, junk;
    logic [IW-1:0] i0, i1, i2, i3, i4;

    initial begin
        a = 32'h01104020; b = 32'h02205040; c = 32'h03306060;
        d = 32'h04407080; e = 32'h055080A0; f = 32'h066090C0;
        x = 32'h8D4F0008; y = 32'h0BADF00D; junk = 32'hDEADBEEF;
        i0 = 32'h0A000000; i1 = 32'h0A000001; i2 = 32'h0A000002;
        i3 = 32'h0A000003; i4 = 32'h0A000004;

        reset = 1'b0;
        drive(1'b1, junk, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("reset_valid", 160'(stage_valid), 160'(5'b00000));
        chk("reset_instr", stage_instr, '0);
        chk("reset_occ", 160'(occupancy), 160'(0));
        chk("reset_cycle", 160'(cycle_cnt), 160'(0));

        // Three live instructions, then reset asserted between edges.
        reset = 1'b1;
        drive(1'b1, 32'h11110001, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h11110002, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h11110003, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_rst_valid", 160'(stage_valid), 160'(5'b00111));
        chk("pre_rst_cycle", 160'(cycle_cnt), 160'(3));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_valid", 160'(stage_valid), 160'(5'b00000));
        chk("async_rst_instr", stage_instr, '0);
        chk("async_rst_cycle", 160'(cycle_cnt), 160'(0));
        step();
        chk("rst_hold_valid", 160'(stage_valid), 160'(5'b00000));
        chk("rst_hold_cycle", 160'(cycle_cnt), 160'(0));
        reset = 1'b1;
        drive(1'b1, 32'h20080018, 1'b0, 1'b0, 1'b0);
        step();
        chk("post_rst_valid", 160'(stage_valid), 160'(5'b00001));
        chk("post_rst_s0", 160'(stage_instr[31:0]), 160'(32'h20080018));
        chk("post_rst_cycle", 160'(cycle_cnt), 160'(1));

        // Clean start for straight flow.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        drive(1'b1, a, 1'b0, 1'b0, 1'b0);
        step();
        chk("flow_e1_valid", 160'(stage_valid), 160'(5'b00001));
        chk("flow_e1_s0", 160'(stage_instr[31:0]), 160'(a));
        drive(1'b1, b, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, c, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, d, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, e, 1'b0, 1'b0, 1'b0);
        step();
        chk("flow_e5_retv", 160'(retire_valid), 160'(1'b1));
        chk("flow_e5_reti", 160'(retire_instr), 160'(a));
        chk("flow_e5_occ", 160'(occupancy), 160'(5));
        chk("flow_e5_all", stage_instr, {a, b, c, d, e});
        chk("flow_e5_retcnt", 160'(retired_cnt), 160'(0));
        drive(1'b1, f, 1'b0, 1'b0, 1'b0);
        step();
        chk("flow_e6_retcnt", 160'(retired_cnt), 160'(1));
        chk("flow_e6_reti", 160'(retire_instr), 160'(b));
        chk("flow_e6_cycle", 160'(cycle_cnt), 160'(6));
        drive(1'b0, junk, 1'b0, 1'b0, 1'b0);
        step();
        chk("flow_e7_all", stage_instr, {c, d, e, f, 32'h0});
        chk("flow_e7_valid", 160'(stage_valid), 160'(5'b11110));
        chk("flow_e7_retcnt", 160'(retired_cnt), 160'(2));

        // Stall: X held in stage 0, bubbles at stage 1, older stages drain.
        drive(1'b1, x, 1'b0, 1'b0, 1'b0);
        step();
        chk("stall_pre_all", stage_instr, {d, e, f, 32'h0, x});
        drive(1'b1, 32'h12345678, 1'b1, 1'b0, 1'b0);
        step();
        chk("stall1_all", stage_instr, {e, f, 32'h0, 32'h0, x});
        chk("stall1_valid", 160'(stage_valid), 160'(5'b11001));
        chk("stall1_cnt", 160'(stall_cnt), 160'(1));
        step();
        chk("stall2_all", stage_instr, {f, 32'h0, 32'h0, 32'h0, x});
        chk("stall2_valid", 160'(stage_valid), 160'(5'b10001));
        chk("stall2_cnt", 160'(stall_cnt), 160'(2));
        chk("stall2_retcnt", 160'(retired_cnt), 160'(5));
        drive(1'b0, junk, 1'b0, 1'b0, 1'b0);
        step();
        chk("unstall_valid", 160'(stage_valid), 160'(5'b00010));
        chk("unstall_s1", 160'(stage_instr[63:32]), 160'(x));
        chk("unstall_cnt", 160'(stall_cnt), 160'(2));
        chk("unstall_retcnt", 160'(retired_cnt), 160'(6));
        chk("unstall_cycle", 160'(cycle_cnt), 160'(11));

        // clr zeroes counters only.
        drive(1'b0, junk, 1'b0, 1'b0, 1'b1);
        step();
        chk("clr_cycle", 160'(cycle_cnt), 160'(0));
        chk("clr_stall", 160'(stall_cnt), 160'(0));
        chk("clr_retired", 160'(retired_cnt), 160'(0));
        chk("clr_valid", 160'(stage_valid), 160'(5'b00100));

        // Fill I0..I4, then flush.
        drive(1'b1, i0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, i1, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, i2, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, i3, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, i4, 1'b0, 1'b0, 1'b0);
        step();
        chk("fill_all", stage_instr, {i0, i1, i2, i3, i4});
        chk("fill_retcnt", 160'(retired_cnt), 160'(1));
        drive(1'b1, junk, 1'b0, 1'b1, 1'b0);
        step();
        chk("flush_valid", 160'(stage_valid), 160'(5'b11100));
        chk("flush_all", stage_instr, {i1, i2, i3, 32'h0, 32'h0});
        chk("flush_cnt", 160'(flush_cnt), 160'(1));
        chk("flush_retcnt", 160'(retired_cnt), 160'(2));
        drive(1'b1, junk, 1'b1, 1'b1, 1'b0);
        step();
        chk("flst_all", stage_instr, {i2, i3, 32'h0, 32'h0, 32'h0});
        chk("flst_valid", 160'(stage_valid), 160'(5'b11000));
        chk("flst_flush", 160'(flush_cnt), 160'(2));
        chk("flst_stall", 160'(stall_cnt), 160'(0));
        chk("flst_retcnt", 160'(retired_cnt), 160'(3));
        drive(1'b0, junk, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("drain_occ", 160'(occupancy), 160'(0));
        chk("drain_retcnt", 160'(retired_cnt), 160'(5));
        chk("drain_cycle", 160'(cycle_cnt), 160'(9));

        // Stall on an empty pipe still counts; then saturate.
        drive(1'b1, junk, 1'b1, 1'b0, 1'b0);
        step();
        chk("empty_stall_cnt", 160'(stall_cnt), 160'(1));
        chk("empty_stall_valid", 160'(stage_valid), 160'(5'b00000));
        for (int k = 0; k < 20; k++) step();
        chk("sat_stall", 160'(stall_cnt), 160'(15));
        chk("sat_cycle", 160'(cycle_cnt), 160'(15));
        chk("sat_retired", 160'(retired_cnt), 160'(5));
        drive(1'b1, y, 1'b0, 1'b0, 1'b0);
        step();
        chk("sat_hold_stall", 160'(stall_cnt), 160'(15));
        chk("sat_hold_cycle", 160'(cycle_cnt), 160'(15));
        chk("load_y_valid", 160'(stage_valid), 160'(5'b00001));
        drive(1'b1, junk, 1'b1, 1'b0, 1'b1);
        step();
        chk("clrst_stall", 160'(stall_cnt), 160'(0));
        chk("clrst_cycle", 160'(cycle_cnt), 160'(0));
        chk("clrst_valid", 160'(stage_valid), 160'(5'b00001));
        chk("clrst_s0", 160'(stage_instr[31:0]), 160'(y));
        drive(1'b1, junk, 1'b1, 1'b0, 1'b0);
        step();
        chk("after_clr_stall", 160'(stall_cnt), 160'(1));
        chk("after_clr_cycle", 160'(cycle_cnt), 160'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
